// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: state encoding, default parameters and a clog2 helper
// shared by the gated frequency counter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int unsigned GATE_CYCLES_DEF = 32'd33554432;
    localparam int          CNT_W_DEF       = 24;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/freq_meter_sync_rise.sv
// sync_rise: 2-FF synchronizer for an asynchronous input followed by a
// rising-edge detector, reusable for any asynchronous board input.
module sync_rise (
    input  logic fcrystal,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s0, s1, prev;

    always_ff @(posedge fcrystal or negedge rst_n) begin
        if (!rst_n) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s0   <= d;
            s1   <= s0;
            prev <= s1;
        end
    end

    assign rise = s1 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of fin over GATE_CYCLES fcrystal cycles
// and reports the saturated count with a one-cycle done strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int          CNT_W       = CNT_W_DEF
) (
    input  logic             fcrystal,
    input  logic             rst_n,
    input  logic             fin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int              GW   = clog2(64'(GATE_CYCLES));
    localparam logic [GW-1:0]   LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    state_t           state;
    logic [GW-1:0]    gate;
    logic [CNT_W-1:0] edges, edges_nxt;
    logic             ovf_int, ovf_nxt, rise, sat;

    sync_rise u_sync (
        .fcrystal(fcrystal),
        .rst_n   (rst_n),
        .d       (fin),
        .rise    (rise)
    );

    assign sat       = edges == MAX;
    assign edges_nxt = (rise && !sat) ? edges + CNT_W'(1) : edges;
    assign ovf_nxt   = ovf_int | (rise & sat);

    // The last gate cycle's rise is folded into count/ovf so they are valid alongside done.
    always_ff @(posedge fcrystal or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gate    <= '0;
            edges   <= '0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= MEASURE;
                    gate    <= '0;
                    edges   <= '0;
                    ovf_int <= 1'b0;
                    busy    <= 1'b1;
                end
                MEASURE: begin
                    gate    <= gate + GW'(1);
                    edges   <= edges_nxt;
                    ovf_int <= ovf_nxt;
                    if (gate == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        count <= edges_nxt;
                        ovf   <= ovf_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven and randomized checks of freq_meter with
// GATE_CYCLES=100, against CNT_W=8 and CNT_W=4 instances sharing stimulus.
module tb_freq_meter;

    localparam int G = 100;
    localparam int T = 4;

    typedef struct {
        int p;
        int h;
        int off;
        int sx;
        int e8;
        int e4;
        int o4;
    } vec_t;

    logic       fcrystal, rst_n, fin, start;
    logic       busy8, done8, ovf8, busy4, done4, ovf4;
    logic [7:0] count8;
    logic [3:0] count4;
    int         checks, errors;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
        .fcrystal(fcrystal), .rst_n(rst_n), .fin(fin), .start(start),
        .busy(busy8), .done(done8), .count(count8), .ovf(ovf8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .fcrystal(fcrystal), .rst_n(rst_n), .fin(fin), .start(start),
        .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
    );

    initial fcrystal = 1'b0;
    always #5 fcrystal = ~fcrystal;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic s);
        fin   = f;
        start = s;
        @(posedge fcrystal);
        #1;
    endtask

    // p=0 means a single pulse of width h starting at cycle off.
    function automatic logic fin_at(input int p, input int h, input int off, input int i);
        if (i < off) return 1'b0;
        if (p == 0) return i < off + h;
        return ((i - off) % p) < h;
    endfunction

    // A 0->1 step in fin between samples k-1 and k surfaces as rise two
    // cycles later; it lands in the gate iff k is in [T-1, T+G-2].
    function automatic int model(input int p, input int h, input int off);
        int c;
        c = 0;
        for (int k = T - 1; k <= T + G - 2; k++)
            if (fin_at(p, h, off, k) && !fin_at(p, h, off, k - 1)) c++;
        return c;
    endfunction

    task automatic meas(input string nm, input vec_t v);
        int nd, first, nb;
        nd = 0;
        first = -1;
        nb = 0;
        for (int i = 0; i < T + G + 6; i++) begin
            cyc(fin_at(v.p, v.h, v.off, i), (i == T) || (i == v.sx));
            if (done8) begin
                nd++;
                if (first < 0) first = i;
            end
            nb += int'(busy8);
        end
        chk({nm, "_ndone"}, nd, 1);
        chk({nm, "_lat"}, first, T + G);
        chk({nm, "_busy"}, nb, G + 1);
        chk({nm, "_cnt8"}, int'(count8), v.e8);
        chk({nm, "_ovf8"}, int'(ovf8), 0);
        chk({nm, "_cnt4"}, int'(count4), v.e4);
        chk({nm, "_ovf4"}, int'(ovf4), v.o4);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int   dq[$];
        int   nd, nb, c;
        checks = 0;
        errors = 0;
        tbl[0] = '{p: 4,  h: 2, off: 3,   sx: -1, e8: 25, e4: 15, o4: 1};
        tbl[1] = '{p: 10, h: 5, off: 3,   sx: -1, e8: 10, e4: 10, o4: 0};
        tbl[2] = '{p: 4,  h: 2, off: 1,   sx: 54, e8: 25, e4: 15, o4: 1};
        tbl[3] = '{p: 0,  h: 4, off: 3,   sx: -1, e8: 1,  e4: 1,  o4: 0};
        tbl[4] = '{p: 0,  h: 4, off: 102, sx: -1, e8: 1,  e4: 1,  o4: 0};
        tbl[5] = '{p: 0,  h: 4, off: 103, sx: -1, e8: 0,  e4: 0,  o4: 0};

        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(i[0], 1'b1);
            chk("rst_hold", int'({busy8, done8, ovf8, count8, busy4, done4, ovf4, count4}), 0);
        end
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) meas($sformatf("tbl%0d", n), tbl[n]);

        for (int n = 0; n < 8; n++) begin
            rv.p   = int'($urandom_range(12, 4));
            rv.h   = int'($urandom_range(rv.p - 2, 2));
            rv.off = int'($urandom_range(10, 0));
            rv.sx  = -1;
            c      = model(rv.p, rv.h, rv.off);
            rv.e8  = c > 255 ? 255 : c;
            rv.e4  = c > 15 ? 15 : c;
            rv.o4  = int'(c > 15);
            meas($sformatf("rnd%0d_p%0d_h%0d", n, rv.p, rv.h), rv);
        end

        for (int i = 0; i <= T + 50; i++) cyc(fin_at(4, 2, 3, i), i == T);
        #2 rst_n = 1'b0;
        #1 chk("abort_out", int'({busy8, done8, ovf8, count8, busy4, done4, ovf4, count4}), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 120; i++) begin
            cyc(fin_at(4, 2, 0, i), 1'b0);
            nd += int'(done8) + int'(done4);
            nb += int'(busy8) + int'(busy4);
        end
        chk("abort_nodone", nd, 0);
        chk("abort_nobusy", nb, 0);
        meas("after_abort", tbl[0]);

        for (int i = 0; i < T + 3 * (G + 2) + 10; i++) begin
            cyc(fin_at(4, 2, 3, i), (i >= T) && (i <= T + 2 * (G + 2)));
            if (done8) begin
                dq.push_back(i);
                chk("held_cnt8", int'(count8), 25);
            end
        end
        chk("held_ndone", dq.size(), 3);
        if (dq.size() > 0) chk("held_first", dq[0], T + G);
        for (int k = 1; k < dq.size(); k++) chk("held_gap", dq[k] - dq[k-1], G + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
